// File: rtl/rpn_stack_calc.sv
// RPN calculator: a small operand stack driven by debounced push/exec/undo pulses.
// A one-hot-free FSM sequences each command; all outputs decode registered state.
module rpn_stack_calc #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             op_in,
  input  logic             undo_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic [1:0]       opcode_in,
  output logic [WIDTH-1:0] top_out,
  output logic [DW-1:0]    depth_out,
  output logic [2:0]       status_out,
  output logic             result_valid,
  output logic             error_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    POP   = 3'd2,
    EXEC  = 3'd3,
    SHOW  = 3'd4,
    ERROR = 3'd7
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [DW-1:0]    depth;
  logic [WIDTH-1:0] hold;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] result;
  logic [AW-1:0]    wr_idx, top_idx, nos_idx;

  assign wr_idx  = AW'(depth);
  assign top_idx = AW'(depth - 1'b1);
  assign nos_idx = AW'(depth - 2'd2);

  always_comb begin
    result = '0;
    unique case (opcode)
      2'b00: result = stack[nos_idx] + stack[top_idx];
      2'b01: result = stack[nos_idx] - stack[top_idx];
      2'b10: result = stack[nos_idx] & stack[top_idx];
      2'b11: result = stack[nos_idx] | stack[top_idx];
      default: result = '0;
    endcase
  end

  // undo outranks data, which outranks op; the if/else chain encodes that order.
  always_comb begin
    next_state = IDLE;
    unique case (state)
      IDLE: begin
        if (undo_in)
          next_state = (depth != '0) ? POP : IDLE;
        else if (data_in)
          next_state = (depth == DW'(DEPTH)) ? ERROR : PUSH;
        else if (op_in)
          next_state = (depth >= DW'(2)) ? EXEC : ERROR;
        else
          next_state = IDLE;
      end
      PUSH:  next_state = IDLE;
      POP:   next_state = IDLE;
      EXEC:  next_state = SHOW;
      SHOW:  next_state = IDLE;
      ERROR: next_state = undo_in ? IDLE : ERROR;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      depth  <= '0;
      hold   <= '0;
      opcode <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == PUSH) hold <= value_in;
      if (state == IDLE && next_state == EXEC) opcode <= opcode_in;
      unique case (state)
        PUSH:       depth <= depth + 1'b1;
        POP, EXEC:  depth <= depth - 1'b1;
        default:    depth <= depth;
      endcase
    end
  end

  // Storage is deliberately unreset; entries at or above depth are never visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == PUSH) stack[wr_idx]  <= hold;
      if (state == EXEC) stack[nos_idx] <= result;
    end
  end

  always_comb begin
    top_out = '0;
    if (depth != '0) top_out = stack[top_idx];
  end

  assign depth_out    = depth;
  assign status_out   = state;
  assign result_valid = (state == SHOW);
  assign error_out    = (state == ERROR);

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed self-checking bench for rpn_stack_calc (WIDTH=16, DEPTH=4).
module tb_rpn_stack_calc;

  logic        clk;
  logic        reset;
  logic        data_in, op_in, undo_in;
  logic [15:0] value_in;
  logic [1:0]  opcode_in;
  logic [15:0] top_out;
  logic [2:0]  depth_out;
  logic [2:0]  status_out;
  logic        result_valid, error_out;

  int errors = 0;
  int checks = 0;

  rpn_stack_calc #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .op_in(op_in), .undo_in(undo_in),
    .value_in(value_in), .opcode_in(opcode_in), .top_out(top_out), .depth_out(depth_out),
    .status_out(status_out), .result_valid(result_valid), .error_out(error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Push v; value_in is scrambled after the capture edge so the hold register matters.
  task automatic push(input logic [15:0] v);
    data_in = 1'b1; value_in = v;
    tick();
    data_in = 1'b0; value_in = 16'hDEAD;
    tick();
  endtask

  task automatic exec(input logic [1:0] op);
    op_in = 1'b1; opcode_in = op;
    tick();
    op_in = 1'b0; opcode_in = ~op;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (status_out !== 3'd0) begin errors++; $display("FAIL reset_status: got %0d expected 0", status_out); end
    checks++; if (depth_out !== 3'd0) begin errors++; $display("FAIL reset_depth: got %0d expected 0", depth_out); end
    checks++; if (top_out !== 16'h0) begin errors++; $display("FAIL reset_top: got %0h expected 0", top_out); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", result_valid); end
    checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b expected 0", error_out); end
  endtask

  task automatic test_sub_sequence();
    logic [2:0] exp_seq [8];
    exp_seq = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd3, 3'd4, 3'd0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (status_out !== exp_seq[i]) begin
        errors++; $display("FAIL sub_status[%0d]: got %0d expected %0d", i, status_out, exp_seq[i]);
      end
      if (i == 4) begin
        checks++; if (top_out !== 16'd3 || depth_out !== 3'd2) begin errors++; $display("FAIL sub_pushed: got top=%0h depth=%0d expected top=3 depth=2", top_out, depth_out); end
      end
      if (i == 6) begin
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL sub_valid: got %0b expected 1", result_valid); end
        checks++; if (top_out !== 16'd2) begin errors++; $display("FAIL sub_result: got %0h expected 2", top_out); end
      end
      data_in = (i == 0 || i == 2); value_in = (i == 0) ? 16'd5 : 16'd3;
      op_in = (i == 4); opcode_in = 2'b01;
      tick();
      data_in = 1'b0; op_in = 1'b0; value_in = 16'hDEAD; opcode_in = 2'b10;
    end
    checks++; if (depth_out !== 3'd1) begin errors++; $display("FAIL sub_depth: got %0d expected 1", depth_out); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL sub_valid_drop: got %0b expected 0", result_valid); end
  endtask

  task automatic test_add_wrap();
    do_reset();
    push(16'hFFFF);
    push(16'h0002);
    exec(2'b00);
    checks++; if (top_out !== 16'h0001) begin errors++; $display("FAIL add_wrap_top: got %0h expected 1", top_out); end
    checks++; if (depth_out !== 3'd1) begin errors++; $display("FAIL add_wrap_depth: got %0d expected 1", depth_out); end
    checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL add_wrap_error: got %0b expected 0", error_out); end
  endtask

  task automatic test_logic_ops();
    do_reset();
    push(16'h0F0F);
    push(16'h00FF);
    exec(2'b10);
    checks++; if (top_out !== 16'h000F || depth_out !== 3'd1) begin errors++; $display("FAIL and_op: got top=%0h depth=%0d expected top=f depth=1", top_out, depth_out); end
    push(16'hF000);
    exec(2'b11);
    checks++; if (top_out !== 16'hF00F || depth_out !== 3'd1) begin errors++; $display("FAIL or_op: got top=%0h depth=%0d expected top=f00f depth=1", top_out, depth_out); end
    push(16'h0001);
    exec(2'b01);
    checks++; if (top_out !== 16'hF00E) begin errors++; $display("FAIL sub_order: got %0h expected f00e", top_out); end
  endtask

  task automatic test_full_error();
    do_reset();
    push(16'd1); push(16'd2); push(16'd3); push(16'd4);
    checks++; if (depth_out !== 3'd4 || top_out !== 16'd4) begin errors++; $display("FAIL full_fill: got top=%0h depth=%0d expected top=4 depth=4", top_out, depth_out); end
    data_in = 1'b1; value_in = 16'd9;
    tick();
    data_in = 1'b0;
    checks++; if (status_out !== 3'd7 || error_out !== 1'b1) begin errors++; $display("FAIL full_error: got status=%0d err=%0b expected status=7 err=1", status_out, error_out); end
    checks++; if (depth_out !== 3'd4) begin errors++; $display("FAIL full_depth: got %0d expected 4", depth_out); end
    op_in = 1'b1; tick(); op_in = 1'b0;
    data_in = 1'b1; tick(); data_in = 1'b0;
    checks++; if (status_out !== 3'd7 || depth_out !== 3'd4) begin errors++; $display("FAIL error_hold: got status=%0d depth=%0d expected status=7 depth=4", status_out, depth_out); end
    undo_in = 1'b1; tick(); undo_in = 1'b0;
    checks++; if (status_out !== 3'd0 || error_out !== 1'b0) begin errors++; $display("FAIL error_clear: got status=%0d err=%0b expected status=0 err=0", status_out, error_out); end
    checks++; if (depth_out !== 3'd4 || top_out !== 16'd4) begin errors++; $display("FAIL error_no_pop: got top=%0h depth=%0d expected top=4 depth=4", top_out, depth_out); end
  endtask

  task automatic test_underflow();
    do_reset();
    push(16'd7);
    op_in = 1'b1; tick(); op_in = 1'b0;
    checks++; if (status_out !== 3'd7 || depth_out !== 3'd1) begin errors++; $display("FAIL op_underflow: got status=%0d depth=%0d expected status=7 depth=1", status_out, depth_out); end
    undo_in = 1'b1; tick(); undo_in = 1'b0;
    undo_in = 1'b1; tick(); undo_in = 1'b0;
    checks++; if (status_out !== 3'd2) begin errors++; $display("FAIL pop_state: got %0d expected 2", status_out); end
    tick();
    checks++; if (depth_out !== 3'd0 || top_out !== 16'h0) begin errors++; $display("FAIL pop_empty: got top=%0h depth=%0d expected top=0 depth=0", top_out, depth_out); end
    undo_in = 1'b1; tick(); undo_in = 1'b0;
    checks++; if (status_out !== 3'd0 || depth_out !== 3'd0) begin errors++; $display("FAIL undo_empty: got status=%0d depth=%0d expected status=0 depth=0", status_out, depth_out); end
  endtask

  task automatic test_priority();
    do_reset();
    push(16'h0011);
    push(16'h0022);
    data_in = 1'b1; undo_in = 1'b1; value_in = 16'h0099;
    tick();
    data_in = 1'b0; undo_in = 1'b0;
    checks++; if (status_out !== 3'd2) begin errors++; $display("FAIL prio_pop_state: got %0d expected 2", status_out); end
    tick();
    checks++; if (depth_out !== 3'd1 || top_out !== 16'h0011) begin errors++; $display("FAIL prio_pop: got top=%0h depth=%0d expected top=11 depth=1", top_out, depth_out); end
    data_in = 1'b1; op_in = 1'b1; value_in = 16'h0044;
    tick();
    op_in = 1'b0;
    checks++; if (status_out !== 3'd1) begin errors++; $display("FAIL prio_push_state: got %0d expected 1", status_out); end
    tick();
    data_in = 1'b0;
    checks++; if (status_out !== 3'd0 || depth_out !== 3'd2 || top_out !== 16'h0044) begin errors++; $display("FAIL prio_push: got status=%0d top=%0h depth=%0d expected status=0 top=44 depth=2", status_out, top_out, depth_out); end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    push(16'd1); push(16'd2); push(16'd3);
    op_in = 1'b1; opcode_in = 2'b00; tick(); op_in = 1'b0;
    checks++; if (status_out !== 3'd3) begin errors++; $display("FAIL rst_exec_state: got %0d expected 3", status_out); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (status_out !== 3'd0 || depth_out !== 3'd0 || top_out !== 16'h0) begin errors++; $display("FAIL rst_exec: got status=%0d top=%0h depth=%0d expected all 0", status_out, top_out, depth_out); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_valid[%0d]: got %0b expected 0", i, result_valid); end
      tick();
    end
    op_in = 1'b1; tick(); op_in = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (status_out !== 3'd0 || error_out !== 1'b0) begin errors++; $display("FAIL rst_error: got status=%0d err=%0b expected status=0 err=0", status_out, error_out); end
  endtask

  initial begin
    reset = 1'b1; data_in = 1'b0; op_in = 1'b0; undo_in = 1'b0;
    value_in = '0; opcode_in = '0;
    test_reset();
    test_sub_sequence();
    test_add_wrap();
    test_logic_ops();
    test_full_error();
    test_underflow();
    test_priority();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
